ctrl_req_arbiter: RTL and testbench
===================================

CTRL_REQ_ARBITER -- requirements
Module: ctrl_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request address width in bits (bank group, bank, row and column packed).
REQ-002 Parameter QDEPTH, fixed at 4, request queue depth in entries; other values are unsupported.
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 req0_valid  in  1  port-0 request present.
REQ-006 req0_rw  in  1  port-0 direction: 1 = read, 0 = write.
REQ-007 req0_addr  in  ADDR_W  port-0 address.
REQ-008 req0_ready  out  1  port-0 request accepted this cycle when req0_valid is also high.
REQ-009 req1_valid, req1_rw, req1_addr, req1_ready SHALL mirror REQ-005..REQ-008 for port 1.
REQ-010 ref_req  in  1  refresh needed; level, held until ref_done.
REQ-011 ref_grant  out  1  refresh owns the command path.
REQ-012 ref_done  in  1  single-cycle pulse: refresh sequence finished.
REQ-013 cmd_valid  out  1  queued command offered to the controller FSM.
REQ-014 cmd_rw, cmd_addr, cmd_src  out  1/ADDR_W/1  head-entry direction, address and originating port.
REQ-015 cmd_ready  in  1  FSM accepts the offered command.
REQ-016 q_count  out  3  current queue occupancy, 0..4.

Function
REQ-017 Enqueue SHALL be limited to at most one request per cycle; a request transfers when valid and ready are both high.
REQ-018 Readiness: reqN_ready = (q_count < 4) AND (port N wins arbitration), computed from registered occupancy only, so there is no pass-through when full, even on a simultaneous dequeue.
REQ-019 Arbitration: single valid port wins; both valid, the port not granted last wins; the last-winner register updates only on a transfer.
REQ-020 Queue SHALL be strict FIFO, storing {rw, addr, src}.
REQ-021 Queue pointers: 2 bits, wrap 3->0.
REQ-022 Occupancy: count +1 on enqueue only, -1 on dequeue only, unchanged on both.
REQ-023 Enqueue SHALL continue in every FSM state, including REFRESH.
REQ-024 FSM states: IDLE, ISSUE, REFRESH.
REQ-025 IDLE: ref_req -> REFRESH (priority); else q_count != 0 -> ISSUE; else stay.
REQ-026 ISSUE: cmd_valid = 1, head presented combinationally from queue storage.
REQ-027 ISSUE: dequeue on cmd_valid AND cmd_ready; on dequeue, ref_req -> REFRESH, else q_count == 1 -> IDLE, else stay.
REQ-028 ISSUE: once cmd_valid is high, it and cmd_rw/cmd_addr/cmd_src SHALL hold stable until the handshake; ref_req never withdraws an offered command.
REQ-029 REFRESH: ref_grant = 1, cmd_valid = 0; ref_done -> IDLE; ref_done outside REFRESH is ignored.
REQ-030 cmd_valid, ref_grant SHALL be decoded only from the state register, never from ref_req directly.
REQ-031 Latency: transfer into an empty queue in IDLE at edge N -> state ISSUE after edge N+1, cmd_valid high in the following cycle.
REQ-032 Throughput: back-to-back dequeues at one per cycle while cmd_ready stays high and the queue is non-empty.

Reset
REQ-033 reset_n low at a clock edge -> next state IDLE, q_count 0, pointers 0, last-winner = port 1 (port 0 wins first tie).
REQ-034 Outputs during and after reset: cmd_valid 0, ref_grant 0, req0_ready and req1_ready 0.
REQ-035 Reset mid-operation (ISSUE or REFRESH, any occupancy) SHALL flush the queue with no command emitted afterwards.
REQ-036 req ready outputs SHALL stay 0 in every cycle reset_n is low.

Verification
REQ-037 Both ports valid continuously for 4 cycles from reset, cmd_ready 0 -> accepted src order 0,1,0,1; q_count 4; both ready 0.
REQ-038 Full queue, cmd_ready pulsed 1 cycle with req0 valid -> one dequeue, q_count 3 next cycle, req0 accepted the cycle after.
REQ-039 Single write addr 0x0000_1234 into idle empty queue -> cmd_valid high two cycles later with cmd_addr 0x0000_1234, cmd_rw 0, cmd_src 0.
REQ-040 ref_req raised while a command is offered and cmd_ready is 0 -> command held stable; after the handshake, REFRESH with ref_grant 1; ref_done -> IDLE, then ISSUE if non-empty.
REQ-041 3 entries queued, reset_n low 1 cycle during ISSUE -> q_count 0, cmd_valid 0, no further commands without new requests.
REQ-042 ref_done pulsed in IDLE with ref_req 0 -> no state change, ref_grant stays 0.

Source files
------------

// File: rtl/ctrl_req_arbiter.sv
// ctrl_req_arbiter
//   Two-port request arbiter feeding a 4-entry FIFO that presents one command
//   at a time to a memory-controller FSM, with refresh taking the command path
//   between commands.
//
//   Ports
//     clock, reset_n            sole clock; synchronous active-low reset
//     req0_valid/rw/addr/ready  port-0 request handshake (rw: 1 = read)
//     req1_valid/rw/addr/ready  port-1 request handshake
//     ref_req                   refresh needed (level, held until ref_done)
//     ref_grant                 refresh owns the command path
//     ref_done                  one-cycle pulse, refresh sequence finished
//     cmd_valid/rw/addr/src     head-of-queue command offered to the FSM
//     cmd_ready                 FSM accepts the offered command
//     q_count                   queue occupancy, 0..4
//
//   QDEPTH is fixed at 4; the 2-bit pointers rely on that and wrap 3->0.
module ctrl_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int QDEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  input  logic              ref_req,
  output logic              ref_grant,
  input  logic              ref_done,
  output logic              cmd_valid,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_src,
  input  logic              cmd_ready,
  output logic [2:0]        q_count
);

  localparam logic [2:0] FULL_CNT = 3'(QDEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, REFRESH} state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic              src;
  } entry_t;

  state_t      state;
  entry_t      q_mem [QDEPTH];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        last_win;   // port that won the most recent transfer

  logic        win0;
  logic        win1;
  logic        not_full;
  logic        enq;
  logic        deq;
  entry_t      enq_entry;

  // Arbitration: a lone valid port wins; on a tie the port that did not win
  // the last transfer goes first.
  assign win0     = req0_valid & (~req1_valid | last_win);
  assign win1     = req1_valid & (~req0_valid | ~last_win);

  // Readiness looks only at registered occupancy, so a full queue never
  // accepts even when the head is leaving in the same cycle.
  assign not_full   = (count < FULL_CNT);
  assign req0_ready = reset_n & not_full & win0;
  assign req1_ready = reset_n & not_full & win1;

  // At most one ready is high, so at most one request transfers per cycle.
  assign enq = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    enq_entry      = '0;
    enq_entry.src  = req1_ready;
    enq_entry.rw   = req1_ready ? req1_rw   : req0_rw;
    enq_entry.addr = req1_ready ? req1_addr : req0_addr;
  end

  // Command path is decoded purely from the state register; the head entry is
  // read straight out of storage and cannot change until it is dequeued.
  assign cmd_valid = (state == ISSUE);
  assign ref_grant = (state == REFRESH);
  assign deq       = cmd_valid & cmd_ready;

  assign cmd_rw   = q_mem[rd_ptr].rw;
  assign cmd_addr = q_mem[rd_ptr].addr;
  assign cmd_src  = q_mem[rd_ptr].src;
  assign q_count  = count;

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_mem[wr_ptr] <= enq_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= 3'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      last_win <= 1'b1;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + 2'd1;
        last_win <= enq_entry.src;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 2'd1;
      end

      case ({enq, deq})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (ref_req) begin
            state <= REFRESH;
          end else if (count != 3'd0) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // A pending refresh waits for the offered command's handshake.
          if (deq) begin
            if (ref_req) begin
              state <= REFRESH;
            end else if (count == 3'd1) begin
              state <= IDLE;
            end
          end
        end
        REFRESH: begin
          if (ref_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_req_arbiter.sv
module tb_ctrl_req_arbiter;

  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0_valid, req0_rw, req0_ready;
  logic [AW-1:0] req0_addr;
  logic          req1_valid, req1_rw, req1_ready;
  logic [AW-1:0] req1_addr;
  logic          ref_req, ref_grant, ref_done;
  logic          cmd_valid, cmd_rw, cmd_src, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    q_count;

  always #5 clock = ~clock;

  ctrl_req_arbiter #(.ADDR_W(AW), .QDEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_rw    (req0_rw),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rw    (req1_rw),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .ref_req    (ref_req),
    .ref_grant  (ref_grant),
    .ref_done   (ref_done),
    .cmd_valid  (cmd_valid),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_src    (cmd_src),
    .cmd_ready  (cmd_ready),
    .q_count    (q_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of pending requests plus two flags saying
  // whether a command is being offered or a refresh is in progress.
  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic          src;
  } ent_t;

  ent_t mq[$];
  bit   m_offer;
  bit   m_refresh;
  int   m_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (!reset_n) return -1;
    if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic check_model();
    int w;
    bit room;
    w    = winner();
    room = (mq.size() < 4);
    chk("ready0", {63'd0, req0_ready}, {63'd0, (reset_n && room && w == 0)});
    chk("ready1", {63'd0, req1_ready}, {63'd0, (reset_n && room && w == 1)});
    if (reset_n) begin
      chk("q_count", {61'd0, q_count}, 64'(mq.size()));
      chk("cmd_valid", {63'd0, cmd_valid}, {63'd0, m_offer});
      chk("ref_grant", {63'd0, ref_grant}, {63'd0, m_refresh});
      if (m_offer && mq.size() > 0) begin
        chk("cmd_addr", {32'd0, cmd_addr}, {32'd0, mq[0].addr});
        chk("cmd_rw", {63'd0, cmd_rw}, {63'd0, mq[0].rw});
        chk("cmd_src", {63'd0, cmd_src}, {63'd0, mq[0].src});
      end
    end
  endtask

  task automatic model_update();
    int   w;
    int   sz;
    bit   take;
    ent_t e;
    w  = winner();
    sz = mq.size();
    if (!reset_n) begin
      mq.delete();
      m_offer   = 0;
      m_refresh = 0;
      m_last    = 1;
      return;
    end
    take = m_offer && cmd_ready;
    if (m_refresh) begin
      if (ref_done) m_refresh = 0;
    end else if (m_offer) begin
      if (take) begin
        if (ref_req) begin
          m_offer   = 0;
          m_refresh = 1;
        end else if (sz == 1) begin
          m_offer = 0;
        end
      end
    end else begin
      if (ref_req) m_refresh = 1;
      else if (sz != 0) m_offer = 1;
    end
    if (take) void'(mq.pop_front());
    if (w >= 0 && sz < 4) begin
      e.src  = (w == 1);
      e.rw   = (w == 1) ? req1_rw : req0_rw;
      e.addr = (w == 1) ? req1_addr : req0_addr;
      mq.push_back(e);
      m_last = w;
    end
  endtask

  // Called at posedge+3 with inputs already settled.
  task automatic end_cycle();
    check_model();
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    #2;
    end_cycle();
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_rw = 0; req0_addr = '0;
    req1_valid = 0; req1_rw = 0; req1_addr = '0;
    ref_req = 0; ref_done = 0; cmd_ready = 0;
  endtask

  typedef struct {
    bit v0, v1, cr;
    bit er0, er1;
    int ecnt;
    bit ecv;
    bit esrc;
  } vec_t;

  vec_t vt[10];

  initial begin
    // Tie on both ports from reset, nothing drained, then drain in order.
    vt[0] = '{1, 1, 0, 1, 0, 0, 0, 0};
    vt[1] = '{1, 1, 0, 0, 1, 1, 0, 0};
    vt[2] = '{1, 1, 0, 1, 0, 2, 1, 0};
    vt[3] = '{1, 1, 0, 0, 1, 3, 1, 0};
    vt[4] = '{1, 1, 0, 0, 0, 4, 1, 0};
    vt[5] = '{0, 0, 1, 0, 0, 4, 1, 0};
    vt[6] = '{0, 0, 1, 0, 0, 3, 1, 1};
    vt[7] = '{0, 0, 1, 0, 0, 2, 1, 0};
    vt[8] = '{0, 0, 1, 0, 0, 1, 1, 1};
    vt[9] = '{0, 0, 0, 0, 0, 0, 0, 0};

    m_offer = 0; m_refresh = 0; m_last = 1;
    idle_inputs();
    reset_n = 0;
    @(posedge clock);
    #1;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) cycle();
    reset_n = 1;
    idle_inputs();

    // Table-driven: tie arbitration and FIFO order.
    for (int i = 0; i < 10; i++) begin
      req0_valid = vt[i].v0; req0_rw = 1; req0_addr = 32'h100 + i;
      req1_valid = vt[i].v1; req1_rw = 0; req1_addr = 32'h200 + i;
      cmd_ready  = vt[i].cr;
      #2;
      chk("tbl_ready0", {63'd0, req0_ready}, {63'd0, vt[i].er0});
      chk("tbl_ready1", {63'd0, req1_ready}, {63'd0, vt[i].er1});
      chk("tbl_count", {61'd0, q_count}, 64'(vt[i].ecnt));
      chk("tbl_cmd_valid", {63'd0, cmd_valid}, {63'd0, vt[i].ecv});
      if (vt[i].ecv) chk("tbl_cmd_src", {63'd0, cmd_src}, {63'd0, vt[i].esrc});
      end_cycle();
    end
    idle_inputs();

    // Full queue, one-cycle cmd_ready pulse with port 0 waiting.
    req0_valid = 1;
    for (int i = 0; i < 4; i++) begin
      req0_addr = 32'h300 + i;
      cycle();
    end
    cmd_ready = 1;
    #2;
    chk("full_ready0", {63'd0, req0_ready}, 64'd0);
    chk("full_count", {61'd0, q_count}, 64'd4);
    end_cycle();
    cmd_ready = 0;
    req0_addr = 32'h3AA;
    #2;
    chk("after_pulse_count", {61'd0, q_count}, 64'd3);
    chk("after_pulse_ready0", {63'd0, req0_ready}, 64'd1);
    end_cycle();
    req0_valid = 0;
    #2;
    chk("refill_count", {61'd0, q_count}, 64'd4);
    end_cycle();
    cmd_ready = 1;
    for (int i = 0; i < 6; i++) cycle();
    idle_inputs();

    // Single write into an idle empty queue, then refresh while it is offered.
    req0_valid = 1; req0_rw = 0; req0_addr = 32'h0000_1234;
    cycle();
    req0_valid = 0;
    #2;
    chk("lat_cv_early", {63'd0, cmd_valid}, 64'd0);
    end_cycle();
    #2;
    chk("lat_cv", {63'd0, cmd_valid}, 64'd1);
    chk("lat_addr", {32'd0, cmd_addr}, 64'h1234);
    chk("lat_rw", {63'd0, cmd_rw}, 64'd0);
    chk("lat_src", {63'd0, cmd_src}, 64'd0);
    end_cycle();
    ref_req = 1;
    req1_valid = 1; req1_rw = 1; req1_addr = 32'h0000_5678;
    cycle();
    req1_valid = 0;
    #2;
    chk("hold_cv", {63'd0, cmd_valid}, 64'd1);
    chk("hold_addr", {32'd0, cmd_addr}, 64'h1234);
    chk("hold_grant", {63'd0, ref_grant}, 64'd0);
    end_cycle();
    cmd_ready = 1;
    cycle();
    cmd_ready = 0;
    #2;
    chk("ref_grant_on", {63'd0, ref_grant}, 64'd1);
    chk("ref_cv_off", {63'd0, cmd_valid}, 64'd0);
    end_cycle();
    ref_done = 1;
    cycle();
    ref_done = 0; ref_req = 0;
    #2;
    chk("ref_grant_off", {63'd0, ref_grant}, 64'd0);
    end_cycle();
    cmd_ready = 1;
    #2;
    chk("post_ref_cv", {63'd0, cmd_valid}, 64'd1);
    chk("post_ref_addr", {32'd0, cmd_addr}, 64'h5678);
    chk("post_ref_src", {63'd0, cmd_src}, 64'd1);
    end_cycle();
    idle_inputs();

    // Stray ref_done while idle.
    ref_done = 1;
    cycle();
    ref_done = 0;
    #2;
    chk("stray_done_grant", {63'd0, ref_grant}, 64'd0);
    chk("stray_done_cv", {63'd0, cmd_valid}, 64'd0);
    end_cycle();

    // Reset during ISSUE with three entries queued.
    req0_valid = 1;
    for (int i = 0; i < 3; i++) begin
      req0_addr = 32'h400 + i;
      cycle();
    end
    reset_n = 0;
    #2;
    chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
    end_cycle();
    reset_n = 1; req0_valid = 0; cmd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("flush_count", {61'd0, q_count}, 64'd0);
      chk("flush_cv", {63'd0, cmd_valid}, 64'd0);
      end_cycle();
    end
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_rw    = 1'($urandom);
      req0_addr  = $urandom;
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_rw    = 1'($urandom);
      req1_addr  = $urandom;
      cmd_ready  = ($urandom_range(0, 3) != 0);
      if (ref_done) begin
        ref_done = 0;
        ref_req  = 0;
      end else if (ref_req && m_refresh && $urandom_range(0, 3) == 0) begin
        ref_done = 1;
      end else if (!ref_req && $urandom_range(0, 15) == 0) begin
        ref_req = 1;
      end else if (!ref_req && !m_refresh && $urandom_range(0, 31) == 0) begin
        ref_done = 1;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
